// File: rtl/mv_ref_fetch.sv
// Reference-window row fetcher: takes one sub-block MV, issues row reads and streams returned rows.
// Build option MV_REF_FETCH_CLAMP_EN clamps issued addresses to the picture area.
module mv_ref_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIC_W      = 1920,
    parameter int PIC_H      = 1080
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,
    input  logic        MV_VALID,
    output logic        MV_READY,
    input  logic [7:0]  BLK_X,
    input  logic [7:0]  BLK_Y,
    input  logic [14:0] MV_X_INTEGER,
    input  logic [14:0] MV_Y_INTEGER,
    input  logic [3:0]  MV_X_FRAC,
    input  logic [3:0]  MV_Y_FRAC,
    output logic        MEM_RD_EN,
    output logic [15:0] MEM_ADDR_X,
    output logic [15:0] MEM_ADDR_Y,
    input  logic        MEM_RD_VALID,
    input  logic [87:0] MEM_RD_DATA,
    output logic        ROW_VALID,
    input  logic        ROW_READY,
    output logic [87:0] ROW_DATA,
    output logic        ROW_LAST,
    output logic [3:0]  OUT_FRAC_X,
    output logic [3:0]  OUT_FRAC_Y
);

    // state | meaning
    // IDLE  | waiting for a sub-block MV, MV_READY high
    // ISSUE | issuing one row read per cycle while credit allows
    // DRAIN | all reads issued, waiting for the last row to leave the FIFO

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

    if (PIC_W < 11 || PIC_H < 1) begin : g_bad_geom
        $error("mv_ref_fetch: picture must be at least 11 samples wide and 1 row high");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_n;
    logic signed [15:0] start_x, y0;
    logic signed [15:0] start_x_n, y0_n, row_y;
    logic signed [15:0] blk_x_ext, blk_y_ext, mv_x_ext, mv_y_ext;
    logic signed [15:0] addr_x, addr_y;
    logic [3:0]         h_last, issued, returned;
    logic [3:0]         frac_x, frac_y;
    logic [CW-1:0]      outstanding, fifo_count;
    logic [PW-1:0]      wptr, rptr;
    logic [87:0]        fifo_data [FIFO_DEPTH];
    logic               fifo_last [FIFO_DEPTH];
    logic               capture, credit, rd_en, push, pop, head_last, y_frac_nz;

    assign blk_x_ext = {8'd0, BLK_X};
    assign blk_y_ext = {8'd0, BLK_Y};
    assign mv_x_ext  = {MV_X_INTEGER[14], MV_X_INTEGER};
    assign mv_y_ext  = {MV_Y_INTEGER[14], MV_Y_INTEGER};
    assign y_frac_nz = (MV_Y_FRAC != 4'd0);
    assign start_x_n = blk_x_ext + mv_x_ext - 16'sd3;
    assign y0_n      = blk_y_ext + mv_y_ext - (y_frac_nz ? 16'sd3 : 16'sd0);
    assign row_y     = y0 + $signed({12'd0, issued});

`ifdef MV_REF_FETCH_CLAMP_EN
    localparam logic signed [15:0] X_MAX = 16'(PIC_W - 11);
    localparam logic signed [15:0] Y_MAX = 16'(PIC_H - 1);

    // Per-row Y clamp replicates the boundary row for rows outside the picture.
    assign addr_x = (start_x < 16'sd0) ? 16'sd0 : ((start_x > X_MAX) ? X_MAX : start_x);
    assign addr_y = (row_y < 16'sd0) ? 16'sd0 : ((row_y > Y_MAX) ? Y_MAX : row_y);
`else
    assign addr_x = start_x;
    assign addr_y = row_y;
`endif

    // Credit uses registered counts only, so a pop frees its slot one cycle later.
    assign credit    = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIM;
    assign push      = MEM_RD_VALID;
    assign ROW_VALID = (fifo_count != '0);
    assign pop       = ROW_VALID && ROW_READY;
    assign head_last = fifo_last[rptr];
    assign ROW_LAST  = ROW_VALID && head_last;
    assign ROW_DATA  = fifo_data[rptr];
    assign capture   = MV_READY && MV_VALID;

    assign MEM_RD_EN  = rd_en;
    assign MEM_ADDR_X = rd_en ? addr_x : 16'd0;
    assign MEM_ADDR_Y = rd_en ? addr_y : 16'd0;
    assign OUT_FRAC_X = frac_x;
    assign OUT_FRAC_Y = frac_y;

    always_comb begin
        state_n  = state;
        MV_READY = 1'b0;
        rd_en    = 1'b0;
        case (state)
            IDLE: begin
                MV_READY = 1'b1;
                if (MV_VALID) state_n = ISSUE;
            end
            ISSUE: begin
                rd_en = credit;
                if (credit && (issued == h_last)) state_n = DRAIN;
            end
            DRAIN: begin
                if (pop && head_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state       <= IDLE;
            start_x     <= '0;
            y0          <= '0;
            h_last      <= '0;
            issued      <= '0;
            returned    <= '0;
            frac_x      <= '0;
            frac_y      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            state <= state_n;

            if (capture) begin
                start_x  <= start_x_n;
                y0       <= y0_n;
                h_last   <= y_frac_nz ? 4'd10 : 4'd3;
                frac_x   <= MV_X_FRAC;
                frac_y   <= MV_Y_FRAC;
                issued   <= '0;
                returned <= '0;
            end else begin
                if (rd_en) issued <= issued + 4'd1;
                if (push) returned <= returned + 4'd1;
            end

            if (rd_en && !MEM_RD_VALID) outstanding <= outstanding + CW'(1);
            else if (!rd_en && MEM_RD_VALID) outstanding <= outstanding - CW'(1);

            if (push && !pop) fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);

            if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
        end
    end

    // Row storage needs no reset: the cleared count hides stale entries.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wptr] <= MEM_RD_DATA;
            fifo_last[wptr] <= (returned == h_last);
        end
    end

endmodule

// File: tb/tb_mv_ref_fetch.sv
// Directed bench for mv_ref_fetch with a latency-configurable memory model and a row consumer.
module tb_mv_ref_fetch;

    logic               CLK = 1'b0;
    logic               RST_ASYNC_N = 1'b0;
    logic               MV_VALID = 1'b0;
    logic               MV_READY;
    logic [7:0]         BLK_X = '0, BLK_Y = '0;
    logic [14:0]        MV_X_INTEGER = '0, MV_Y_INTEGER = '0;
    logic [3:0]         MV_X_FRAC = '0, MV_Y_FRAC = '0;
    logic               MEM_RD_EN;
    logic signed [15:0] MEM_ADDR_X, MEM_ADDR_Y;
    logic               MEM_RD_VALID = 1'b0;
    logic [87:0]        MEM_RD_DATA = '0;
    logic               ROW_VALID;
    logic               ROW_READY = 1'b0;
    logic [87:0]        ROW_DATA;
    logic               ROW_LAST;
    logic [3:0]         OUT_FRAC_X, OUT_FRAC_Y;

    mv_ref_fetch dut (
        .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N),
        .MV_VALID(MV_VALID), .MV_READY(MV_READY),
        .BLK_X(BLK_X), .BLK_Y(BLK_Y),
        .MV_X_INTEGER(MV_X_INTEGER), .MV_Y_INTEGER(MV_Y_INTEGER),
        .MV_X_FRAC(MV_X_FRAC), .MV_Y_FRAC(MV_Y_FRAC),
        .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR_X(MEM_ADDR_X), .MEM_ADDR_Y(MEM_ADDR_Y),
        .MEM_RD_VALID(MEM_RD_VALID), .MEM_RD_DATA(MEM_RD_DATA),
        .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY), .ROW_DATA(ROW_DATA), .ROW_LAST(ROW_LAST),
        .OUT_FRAC_X(OUT_FRAC_X), .OUT_FRAC_Y(OUT_FRAC_Y)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, lat = 1, ready_mode = 0;
    int n_req = 0, n_pop = 0, max_occ = 0, last_pop_cyc = 0, rise_cyc = 0;
    logic prev_ready = 1'b1;
    logic [3:0] exp_frac_y = '0;

    logic signed [15:0] rd_x[$], rd_y[$], pend_x[$], pend_y[$];
    int                 pend_due[$];
    logic [87:0]        pop_data[$];
    logic               pop_last[$];

    logic signed [15:0] exp_x;
    logic signed [15:0] exp_y [16];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] row_of(input logic signed [15:0] x, input logic signed [15:0] y);
        logic [87:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) d[i*8 +: 8] = x[7:0] + (y[7:0] * 8'd13) + 8'(i);
        return d;
    endfunction

    // Memory model and row consumer, both acting mid-cycle on the falling edge.
    initial forever begin
        int occ;
        @(negedge CLK);
        cyc++;
        if (!RST_ASYNC_N) begin
            pend_x.delete(); pend_y.delete(); pend_due.delete();
            MEM_RD_VALID = 1'b0;
        end else begin
            case (ready_mode)
                0: ROW_READY = 1'b1;
                1: ROW_READY = 1'b0;
                default: ROW_READY = ~ROW_READY;
            endcase
            occ = n_req - n_pop + (MEM_RD_EN ? 1 : 0);
            if (occ > max_occ) max_occ = occ;
            if (MEM_RD_EN) begin
                rd_x.push_back(MEM_ADDR_X); rd_y.push_back(MEM_ADDR_Y);
                pend_x.push_back(MEM_ADDR_X); pend_y.push_back(MEM_ADDR_Y);
                pend_due.push_back(cyc + lat);
                n_req++;
            end
            if (ROW_VALID && ROW_READY) begin
                pop_data.push_back(ROW_DATA); pop_last.push_back(ROW_LAST);
                check("frac_y_hold", OUT_FRAC_Y, exp_frac_y);
                n_pop++;
                if (ROW_LAST) last_pop_cyc = cyc;
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                MEM_RD_VALID = 1'b1;
                MEM_RD_DATA  = row_of(pend_x[0], pend_y[0]);
                void'(pend_x.pop_front()); void'(pend_y.pop_front()); void'(pend_due.pop_front());
            end else begin
                MEM_RD_VALID = 1'b0;
            end
            if (MV_READY && !prev_ready) rise_cyc = cyc;
            prev_ready = MV_READY;
        end
    end

    task automatic clear_records();
        rd_x.delete(); rd_y.delete(); pop_data.delete(); pop_last.delete();
        n_req = 0; n_pop = 0; max_occ = 0;
    endtask

    task automatic run_mv(input int bx, input int by, input int mx, input int my,
                          input int fx, input int fy);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge CLK); #1;
            if (MV_READY) break;
        end
        if (k == 200) check("mv_ready_timeout", 0, 1);
        exp_frac_y   = 4'(fy);
        BLK_X        = 8'(bx);
        BLK_Y        = 8'(by);
        MV_X_INTEGER = 15'(mx);
        MV_Y_INTEGER = 15'(my);
        MV_X_FRAC    = 4'(fx);
        MV_Y_FRAC    = 4'(fy);
        MV_VALID     = 1'b1;
        @(negedge CLK); #1;
        MV_VALID     = 1'b0;
    endtask

    task automatic wait_done(input string tn, input int n);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge CLK); #1;
            if (pop_data.size() >= n && MV_READY) break;
        end
        if (k == 400) check({tn, "_timeout"}, 0, 1);
    endtask

    task automatic verify_run(input string tn, input int n);
        check({tn, "_nreads"}, rd_x.size(), n);
        for (int k = 0; k < n && k < rd_x.size(); k++) begin
            check($sformatf("%s_x%0d", tn, k), rd_x[k], exp_x);
            check($sformatf("%s_y%0d", tn, k), rd_y[k], exp_y[k]);
        end
        check({tn, "_nrows"}, pop_data.size(), n);
        for (int k = 0; k < n && k < pop_data.size(); k++) begin
            check($sformatf("%s_data%0d", tn, k), pop_data[k], row_of(exp_x, exp_y[k]));
            check($sformatf("%s_last%0d", tn, k), pop_last[k], (k == n - 1));
        end
    endtask

    task automatic set_exp(input int x, input int y0, input int n);
        exp_x = 16'(x);
        for (int k = 0; k < n; k++) exp_y[k] = 16'(y0 + k);
    endtask

    initial begin
        #23;
        check("rst_mv_ready", MV_READY, 1'b1);
        check("rst_rd_en", MEM_RD_EN, 1'b0);
        check("rst_row_valid", ROW_VALID, 1'b0);
        check("rst_row_last", ROW_LAST, 1'b0);
        check("rst_addr_x", MEM_ADDR_X, 16'd0);
        check("rst_addr_y", MEM_ADDR_Y, 16'd0);
        check("rst_frac", {OUT_FRAC_X, OUT_FRAC_Y}, 8'd0);
        @(negedge CLK); #2;
        RST_ASYNC_N = 1'b1;

        // 1: integer MV, 4 rows, X=16+5-3=18, Y=8-2=6..9
        clear_records(); set_exp(18, 6, 4);
        run_mv(16, 8, 5, -2, 0, 0);
        wait_done("t1", 4);
        verify_run("t1", 4);
        check("t1_ready_gap", rise_cyc - last_pop_cyc, 1);

        // 2: FRAC_Y=8, 11 rows, Y=3..13
        clear_records(); set_exp(18, 3, 11);
        run_mv(16, 8, 5, -2, 7, 8);
        #1 check("t2_frac_x", OUT_FRAC_X, 4'd7);
        wait_done("t2", 11);
        verify_run("t2", 11);
        check("t2_frac_y_after", OUT_FRAC_Y, 4'd8);

        // 3: backpressure stops issue at FIFO_DEPTH reads
        clear_records(); set_exp(18, 3, 11);
        ready_mode = 1;
        run_mv(16, 8, 5, -2, 0, 4);
        repeat (20) @(negedge CLK);
        #1;
        check("t3_reads_stalled", n_req, 4);
        check("t3_rd_en_low", MEM_RD_EN, 1'b0);
        check("t3_row_valid", ROW_VALID, 1'b1);
        ready_mode = 0;
        wait_done("t3", 11);
        verify_run("t3", 11);

        // 4: latency 3 with toggling ready
        clear_records(); set_exp(18, 3, 11);
        lat = 3; ready_mode = 2;
        run_mv(16, 8, 5, -2, 0, 8);
        wait_done("t4", 11);
        verify_run("t4", 11);
        check("t4_credit_cap", (max_occ <= 4), 1'b1);
        lat = 1; ready_mode = 0;

        // 5: out-of-picture window, Y0 = 0-1-3 = -4
        clear_records();
`ifdef MV_REF_FETCH_CLAMP_EN
        exp_x = 16'sd0;
        for (int k = 0; k < 11; k++) exp_y[k] = (k < 4) ? 16'sd0 : 16'(k - 4);
`else
        set_exp(-13, -4, 11);
`endif
        run_mv(0, 0, -10, -1, 0, 1);
        wait_done("t5", 11);
        verify_run("t5", 11);

        // 6: reset after 5 reads issued, then a clean sub-block
        clear_records();
        run_mv(16, 8, 5, -2, 0, 3);
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK); #1;
            if (n_req >= 5) break;
        end
        check("t6_reached_5", n_req, 5);
        RST_ASYNC_N  = 1'b0;
        MEM_RD_VALID = 1'b0;
        #1;
        check("t6_rd_en", MEM_RD_EN, 1'b0);
        check("t6_row_valid", ROW_VALID, 1'b0);
        check("t6_mv_ready", MV_READY, 1'b1);
        check("t6_frac_y", OUT_FRAC_Y, 4'd0);
        repeat (3) @(negedge CLK);
        #2;
        clear_records();
        RST_ASYNC_N = 1'b1;
        set_exp(18, 3, 11);
        run_mv(16, 8, 5, -2, 0, 8);
        wait_done("t6", 11);
        verify_run("t6", 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
